mod12_cnt_sched: RTL and testbench

MOD12_CNT_SCHED -- requirements
Module: mod12_cnt_sched

---
 rtl/mod12_cnt_sched_pkg.sv | 20 ++
 rtl/mod12_counter.sv | 40 ++++
 rtl/mod12_cnt_sched.sv | 143 ++++++++++++++
 tb/tb_mod12_cnt_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod12_cnt_sched_pkg.sv
// Shared definitions for the mod-12 counter scheduler: command opcodes,
// scheduler FSM states and the counter's top value.
package mod12_cnt_sched_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic [3:0] MOD12_MAX = 4'd11;

endpackage

// File: rtl/mod12_counter.sv
// Mod-12 up/down counter with a synchronous parallel load.
// load_i has priority over counting; mode_i=1 counts up and mode_i=0 counts down.
module mod12_counter
    import mod12_cnt_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       mode_i,
    input  logic [3:0] datain_i,
    output logic [3:0] count_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // NOTE: count_d is assigned first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = datain_i;
        end else if (mode_i) begin
            count_d = (count_q == MOD12_MAX) ? 4'd0 : count_q + 4'd1;
        end else begin
            count_d = (count_q == 4'd0) ? MOD12_MAX : count_q - 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mod12_cnt_sched.sv
// Two-requester round-robin command scheduler that owns a single mod-12 counter.
// Each command is accepted in IDLE, is executed in EXEC and is answered with a one-cycle RESP pulse.
module mod12_cnt_sched
    import mod12_cnt_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [1:0] req0_op,
    input  logic [3:0] req0_arg,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_op,
    input  logic [3:0] req1_arg,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] rsp_count,
    output logic       rsp_err,
    output logic       busy,
    output logic [3:0] count
);

    state_e     state_q;
    op_e        cmd_op_q;
    logic [3:0] cmd_arg_q;
    logic [3:0] rem_q;
    logic       cmd_id_q;
    logic       last_grant_q;
    logic       rsp_valid_q;
    logic       rsp_id_q;
    logic       rsp_err_q;

    logic       any_valid;
    logic       grant_id;
    logic       accept;
    op_e        sel_op;
    logic [3:0] sel_arg;
    logic       sel_err;
    logic       sel_noop;

    logic       ctr_load;
    logic       ctr_mode;
    logic [3:0] ctr_datain;
    logic [3:0] count_w;

    // On contention the requester not granted last wins; a lone requester always wins.
    assign any_valid = req0_valid | req1_valid;
    assign grant_id  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    assign accept    = (state_q == IDLE) & any_valid & ~rst;

    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept & grant_id;

    assign sel_op   = op_e'(grant_id ? req1_op : req0_op);
    assign sel_arg  = grant_id ? req1_arg : req0_arg;
    assign sel_err  = (sel_op == OP_RSVD) || ((sel_op == OP_LOAD) && (sel_arg > MOD12_MAX));
    assign sel_noop = ((sel_op == OP_UP) || (sel_op == OP_DOWN)) && (sel_arg == 4'd0);

    // The counter holds by reloading itself; it only loads arg in EXEC, where arg is known to be < 12.
    always_comb begin
        ctr_load   = 1'b1;
        ctr_mode   = 1'b0;
        ctr_datain = count_w;
        if (state_q == EXEC) begin
            if (cmd_op_q == OP_LOAD) begin
                ctr_datain = cmd_arg_q;
            end else begin
                ctr_load = 1'b0;
                ctr_mode = (cmd_op_q == OP_UP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_op_q     <= OP_LOAD;
            cmd_arg_q    <= 4'd0;
            rem_q        <= 4'd0;
            cmd_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_grant_q <= grant_id;
                        cmd_op_q     <= sel_op;
                        cmd_arg_q    <= sel_arg;
                        cmd_id_q     <= grant_id;
                        rem_q        <= (sel_op == OP_LOAD) ? 4'd1 : sel_arg;
                        if (sel_err || sel_noop) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_id_q    <= grant_id;
                            rsp_err_q   <= sel_err;
                        end else begin
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rem_q <= rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= cmd_id_q;
                        rsp_err_q   <= 1'b0;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_id_q    <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    mod12_counter u_counter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ctr_load),
        .mode_i   (ctr_mode),
        .datain_i (ctr_datain),
        .count_o  (count_w)
    );

    assign count     = count_w;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_count = rsp_valid_q ? count_w : 4'd0;

endmodule

// File: tb/tb_mod12_cnt_sched.sv
// Self-checking bench for mod12_cnt_sched: directed scenarios, then random commands
// checked against an arithmetic model of the counter and the response timing.
module tb_mod12_cnt_sched;

    localparam logic [1:0] LOAD = 2'b00;
    localparam logic [1:0] UP   = 2'b01;
    localparam logic [1:0] DOWN = 2'b10;
    localparam logic [1:0] RSVD = 2'b11;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_arg, req1_arg;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_err, busy;
    logic [3:0] rsp_count, count;

    int checks = 0;
    int errors = 0;
    int ref_count = 0;
    int trace_q[$];

    mod12_cnt_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_arg   (req0_arg),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_arg   (req1_arg),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_count  (rsp_count),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: number of EXEC cycles, final count and error flag of one command.
    function automatic void model_cmd(input logic [1:0] op, input logic [3:0] arg, input int start,
                                      output int k, output int fin, output bit err);
        k = 0; fin = start; err = 1'b0;
        case (op)
            LOAD: if (arg < 12) begin k = 1; fin = int'(arg); end else err = 1'b1;
            UP:   begin k = int'(arg); fin = (start + int'(arg)) % 12; end
            DOWN: begin k = int'(arg); fin = ((start - int'(arg)) % 12 + 12) % 12; end
            default: err = 1'b1;
        endcase
    endfunction

    // Counter value after i executed steps of a command.
    function automatic int step_val(input logic [1:0] op, input logic [3:0] arg, input int start, input int i);
        if (i == 0) return start;
        case (op)
            LOAD:    return int'(arg);
            UP:      return (start + i) % 12;
            DOWN:    return ((start - i) % 12 + 12) % 12;
            default: return start;
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_count = 0;
    endtask

    // Issue one command on one requester; report what was seen until rsp_valid (bounded).
    task automatic send(input int id, input logic [1:0] op, input logic [3:0] arg,
                        output bit ok, output int lat, output logic rid, output logic [3:0] rcnt,
                        output logic rerr, output int anomalies);
        bit got;
        ok = 1'b0; lat = 0; rid = 1'b0; rcnt = 4'd0; rerr = 1'b0; anomalies = 0;
        trace_q.delete();
        @(negedge clk);
        if (id == 0) begin req0_valid = 1'b1; req0_op = op; req0_arg = arg; end
        else begin req1_valid = 1'b1; req1_op = op; req1_arg = arg; end
        #1;
        got = (id == 0) ? req0_ready : req1_ready;
        if ((id == 0) ? req1_ready : req0_ready) anomalies++;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (got) begin
            for (int c = 1; c <= 40; c++) begin
                #1;
                trace_q.push_back(int'(count));
                if (!busy || req0_ready || req1_ready) anomalies++;
                if (rsp_valid) begin
                    ok = 1'b1; lat = c; rid = rsp_id; rcnt = rsp_count; rerr = rsp_err;
                    break;
                end
                if (rsp_id || rsp_err || rsp_count != 4'd0) anomalies++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req0_op = LOAD; req0_arg = 4'd5;
        req1_valid = 1'b1; req1_op = UP;   req1_arg = 4'd2;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count, rsp_err, busy, count} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count, rsp_err, busy, count});
        end
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        ref_count = 0;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, busy, count} !== 6'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got rsp_valid=%b busy=%b count=%0d want 0", rsp_valid, busy, count);
        end
    endtask

    task automatic test_load();
        bit ok; int lat, an; logic rid, rerr; logic [3:0] rcnt;
        send(0, LOAD, 4'd7, ok, lat, rid, rcnt, rerr, an);
        checks++;
        if ({ok, lat[7:0], rid, rcnt, rerr} !== {1'b1, 8'd2, 1'b0, 4'd7, 1'b0}) begin
            errors++;
            $display("FAIL load7: got ok=%0d lat=%0d id=%0d cnt=%0d err=%0d want 1/2/0/7/0", ok, lat, rid, rcnt, rerr);
        end
        checks++;
        if (an !== 0) begin
            errors++;
            $display("FAIL load7_side: got %0d anomalies want 0", an);
        end
        ref_count = 7;
    endtask

    task automatic test_up_wrap();
        bit ok; int lat, an; logic rid, rerr; logic [3:0] rcnt;
        int exp_t[4] = '{10, 11, 0, 1};
        bit bad;
        send(0, LOAD, 4'd10, ok, lat, rid, rcnt, rerr, an);
        send(1, UP, 4'd3, ok, lat, rid, rcnt, rerr, an);
        checks++;
        if ({ok, lat[7:0], rid, rcnt, rerr} !== {1'b1, 8'd4, 1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL up3: got ok=%0d lat=%0d id=%0d cnt=%0d err=%0d want 1/4/1/1/0", ok, lat, rid, rcnt, rerr);
        end
        bad = (trace_q.size() != 4);
        for (int i = 0; i < 4 && !bad; i++) if (trace_q[i] != exp_t[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL up3_trace: got %p want 10,11,0,1", trace_q);
        end
        ref_count = 1;
    endtask

    task automatic test_down_wrap();
        bit ok; int lat, an; logic rid, rerr; logic [3:0] rcnt;
        int exp_t[3] = '{1, 0, 11};
        bit bad;
        send(1, LOAD, 4'd1, ok, lat, rid, rcnt, rerr, an);
        send(0, DOWN, 4'd2, ok, lat, rid, rcnt, rerr, an);
        checks++;
        if ({ok, lat[7:0], rid, rcnt, rerr} !== {1'b1, 8'd3, 1'b0, 4'd11, 1'b0}) begin
            errors++;
            $display("FAIL down2: got ok=%0d lat=%0d id=%0d cnt=%0d err=%0d want 1/3/0/11/0", ok, lat, rid, rcnt, rerr);
        end
        bad = (trace_q.size() != 3);
        for (int i = 0; i < 3 && !bad; i++) if (trace_q[i] != exp_t[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL down2_trace: got %p want 1,0,11", trace_q);
        end
        ref_count = 11;
    endtask

    task automatic test_errors();
        bit ok; int lat, an; logic rid, rerr; logic [3:0] rcnt;
        send(0, LOAD, 4'd4, ok, lat, rid, rcnt, rerr, an);
        send(0, LOAD, 4'd12, ok, lat, rid, rcnt, rerr, an);
        checks++;
        if ({ok, lat[7:0], rid, rcnt, rerr} !== {1'b1, 8'd1, 1'b0, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL load12: got ok=%0d lat=%0d id=%0d cnt=%0d err=%0d want 1/1/0/4/1", ok, lat, rid, rcnt, rerr);
        end
        send(1, RSVD, 4'd3, ok, lat, rid, rcnt, rerr, an);
        checks++;
        if ({ok, lat[7:0], rid, rcnt, rerr} !== {1'b1, 8'd1, 1'b1, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL op11: got ok=%0d lat=%0d id=%0d cnt=%0d err=%0d want 1/1/1/4/1", ok, lat, rid, rcnt, rerr);
        end
        send(0, UP, 4'd0, ok, lat, rid, rcnt, rerr, an);
        checks++;
        if ({ok, lat[7:0], rid, rcnt, rerr} !== {1'b1, 8'd1, 1'b0, 4'd4, 1'b0}) begin
            errors++;
            $display("FAIL up0: got ok=%0d lat=%0d id=%0d cnt=%0d err=%0d want 1/1/0/4/0", ok, lat, rid, rcnt, rerr);
        end
        send(1, LOAD, 4'd11, ok, lat, rid, rcnt, rerr, an);
        checks++;
        if ({ok, lat[7:0], rid, rcnt, rerr} !== {1'b1, 8'd2, 1'b1, 4'd11, 1'b0}) begin
            errors++;
            $display("FAIL load11: got ok=%0d lat=%0d id=%0d cnt=%0d err=%0d want 1/2/1/11/0", ok, lat, rid, rcnt, rerr);
        end
        ref_count = 11;
    endtask

    task automatic test_back_to_back();
        int grants[$];
        int rids[$];
        int rcnts[$];
        int both = 0;
        bit bad;
        apply_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = LOAD; req0_arg = 4'd3;
        req1_valid = 1'b1; req1_op = LOAD; req1_arg = 4'd8;
        for (int c = 0; c < 60 && rids.size() < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready) grants.push_back(0);
            else if (req1_ready) grants.push_back(1);
            if (rsp_valid) begin rids.push_back(int'(rsp_id)); rcnts.push_back(int'(rsp_count)); end
            if (rids.size() == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        bad = (grants.size() != 4) || (rids.size() != 4) || (both != 0);
        for (int i = 0; i < 4 && !bad; i++)
            if (grants[i] != i % 2 || rids[i] != i % 2 || rcnts[i] != ((i % 2) ? 8 : 3)) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rr_alternate: got grants=%p ids=%p counts=%p both=%0d want 0,1,0,1 / 3,8,3,8",
                     grants, rids, rcnts, both);
        end
        ref_count = 8;
    endtask

    task automatic test_reset_mid_exec();
        bit ok; int lat, an; logic rid, rerr; logic [3:0] rcnt;
        int seen_rsp = 0;
        bit got_rsp = 1'b0;
        apply_reset();
        send(0, LOAD, 4'd3, ok, lat, rid, rcnt, rerr, an);
        @(negedge clk);
        req0_valid = 1'b1; req0_op = UP; req0_arg = 4'd5;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_accept: got ready=%b want 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        if (rsp_valid) seen_rsp++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({count, busy} !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid_count: got count=%0d busy=%b want 0/0", count, busy);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen_rsp++;
        end
        checks++;
        if (seen_rsp != 0) begin
            errors++;
            $display("FAIL rst_mid_no_rsp: got %0d rsp pulses want 0", seen_rsp);
        end
        @(negedge clk);
        req0_valid = 1'b1; req0_op = LOAD; req0_arg = 4'd2;
        req1_valid = 1'b1; req1_op = LOAD; req1_arg = 4'd9;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_rr: got ready0=%b ready1=%b want 1/0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 10 && !got_rsp; c++) begin
            #1;
            if (rsp_valid) begin got_rsp = 1'b1; rid = rsp_id; rcnt = rsp_count; end
            else @(negedge clk);
        end
        checks++;
        if (!got_rsp || rid !== 1'b0 || rcnt !== 4'd2) begin
            errors++;
            $display("FAIL rst_mid_drain: got rsp=%0d id=%0d cnt=%0d want 1/0/2", got_rsp, rid, rcnt);
        end
        ref_count = 2;
    endtask

    task automatic test_random();
        bit ok; int lat, an; logic rid, rerr; logic [3:0] rcnt;
        int k, fin; bit err;
        int id; logic [1:0] op; logic [3:0] arg;
        bit bad;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            id  = int'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            arg = 4'($urandom_range(0, 15));
            model_cmd(op, arg, ref_count, k, fin, err);
            send(id, op, arg, ok, lat, rid, rcnt, rerr, an);
            checks++;
            if (!ok || lat != k + 1 || rid !== 1'(id) || int'(rcnt) != fin || rerr !== err || an != 0) begin
                errors++;
                $display("FAIL rand%0d op=%0d arg=%0d: got ok=%0d lat=%0d id=%0d cnt=%0d err=%0d side=%0d want lat=%0d id=%0d cnt=%0d err=%0d",
                         n, op, arg, ok, lat, rid, rcnt, rerr, an, k + 1, id, fin, err);
            end
            bad = (trace_q.size() != k + 1);
            for (int i = 0; i <= k && !bad; i++)
                if (trace_q[i] != step_val(op, arg, ref_count, i)) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL rand%0d_trace op=%0d arg=%0d start=%0d: got %p", n, op, arg, ref_count, trace_q);
            end
            ref_count = fin;
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 2'b00; req0_arg = 4'd0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_arg = 4'd0;
        test_reset();
        test_load();
        test_up_wrap();
        test_down_wrap();
        test_errors();
        test_back_to_back();
        test_reset_mid_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
